// File: rtl/mc_ctrl_if.sv
// Control/handshake bundle between the multicycle controller and its datapath/memories.
// The master side is the controller; the slave side is the surrounding environment.
interface mc_ctrl_if;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_we;
    logic        pc_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    modport master (
        input  run, opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
               alu_a_sel, alu_b_sel, wb_sel, state, trap_cause, instret
    );

    modport slave (
        output run, opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
               alu_a_sel, alu_b_sel, wb_sel, state, trap_cause, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle RV32-style control FSM: fetch/decode/exec/mem/writeback sequencing,
// memory wait timeouts, illegal-opcode trap, halt, and retired-instruction counting.
module mc_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);
    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    state_t          r_state, w_state_next;
    logic [6:0]      r_op, w_op_next;
    logic [WW-1:0]   r_wait, w_wait_next;
    logic [1:0]      r_cause, w_cause_next;
    logic [31:0]     r_instret;

    logic            w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_rf_we;
    logic            w_pc_we, w_pc_sel, w_alu_a_sel, w_alu_b_sel;
    logic [1:0]      w_wb_sel;
    logic            w_is_mem, w_is_store, w_is_jump, w_timeout;

    assign w_is_store = (r_op == OP_STORE);
    assign w_is_mem   = (r_op == OP_LOAD) || w_is_store;
    assign w_is_jump  = (r_op == OP_JAL) || (r_op == OP_JALR);
    assign w_timeout  = (r_wait == WW'(WAIT_MAX - 1));

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_cause_next = r_cause;
        w_imem_req   = 1'b0;
        w_ir_we      = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = 1'b0;
        w_alu_a_sel  = 1'b0;
        w_alu_b_sel  = 1'b0;
        w_wb_sel     = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_we      = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = 2'd2;
                end
            end
            ST_DECODE: begin
                w_op_next = bus.opcode;
                case (bus.opcode)
                    OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: w_state_next = ST_EXEC;
                    OP_SYSTEM: w_state_next = ST_HALT;
                    default: begin
                        w_state_next = ST_TRAP;
                        w_cause_next = 2'd1;
                    end
                endcase
            end
            ST_EXEC: begin
                w_alu_a_sel = (r_op == OP_AUIPC);
                w_alu_b_sel = (r_op != OP_R) && (r_op != OP_BRANCH);
                if (w_is_mem) begin
                    w_state_next = ST_MEM;
                end else if (r_op == OP_BRANCH) begin
                    w_pc_we      = 1'b1;
                    w_pc_sel     = bus.branch_taken;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                if (bus.dmem_ready) begin
                    if (w_is_store) begin
                        w_pc_we      = 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = 2'd3;
                end
            end
            ST_WB: begin
                w_rf_we      = 1'b1;
                w_pc_we      = 1'b1;
                w_pc_sel     = w_is_jump;
                w_state_next = ST_FETCH;
                if (r_op == OP_LOAD)     w_wb_sel = 2'd1;
                else if (w_is_jump)      w_wb_sel = 2'd2;
                else if (r_op == OP_LUI) w_wb_sel = 2'd3;
            end
            default: ;  // HALT and TRAP hold until reset
        endcase
    end

    // The wait counter restarts on every state change and only counts stalled cycles.
    always_comb begin
        w_wait_next = r_wait;
        if (w_state_next != r_state)
            w_wait_next = '0;
        else if ((r_state == ST_FETCH && !bus.imem_ready) ||
                 (r_state == ST_MEM && !bus.dmem_ready))
            w_wait_next = r_wait + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_wait    <= '0;
            r_cause   <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_wait  <= w_wait_next;
            r_cause <= w_cause_next;
            if (w_pc_we) r_instret <= r_instret + 32'd1;
        end
    end

    assign bus.imem_req   = w_imem_req;
    assign bus.ir_we      = w_ir_we;
    assign bus.dmem_req   = w_dmem_req;
    assign bus.dmem_we    = w_dmem_we;
    assign bus.rf_we      = w_rf_we;
    assign bus.pc_we      = w_pc_we;
    assign bus.pc_sel     = w_pc_sel;
    assign bus.alu_a_sel  = w_alu_a_sel;
    assign bus.alu_b_sel  = w_alu_b_sel;
    assign bus.wb_sel     = w_wb_sel;
    assign bus.state      = r_state;
    assign bus.trap_cause = r_cause;
    assign bus.instret    = r_instret;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: instruction flows, branch, timeouts, trap/halt and reset priority.
module tb_mc_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mc_ctrl_if bus ();

    mc_ctrl #(.WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single transaction line per check point for the main state/strobe picture.
    task automatic show(input string tag);
        $display("%s: state=%0d imem_req=%0b ir_we=%0b dmem_req=%0b dmem_we=%0b rf_we=%0b pc_we=%0b pc_sel=%0b wb_sel=%0d cause=%0d instret=%0d",
                 tag, bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                 bus.rf_we, bus.pc_we, bus.pc_sel, bus.wb_sel, bus.trap_cause, bus.instret);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 7'd0;
        bus.branch_taken = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        show("reset");
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        chk("rst_cause", 32'(bus.trap_cause), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("idle_no_run", 32'(bus.state), 32'd0);

        // ADD: 1,2,3,5,1
        bus.opcode = 7'b0110011;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        #1; show("add_fetch");
        chk("add_fetch_state", 32'(bus.state), 32'd1);
        chk("add_fetch_ir_we", 32'(bus.ir_we), 32'd1);
        tick(); chk("add_decode_state", 32'(bus.state), 32'd2);
        chk("add_decode_pc_we", 32'(bus.pc_we), 32'd0);
        tick(); show("add_exec");
        chk("add_exec_state", 32'(bus.state), 32'd3);
        chk("add_exec_alu_b", 32'(bus.alu_b_sel), 32'd0);
        chk("add_exec_rf_we", 32'(bus.rf_we), 32'd0);
        tick(); show("add_wb");
        chk("add_wb_state", 32'(bus.state), 32'd5);
        chk("add_wb_rf_we", 32'(bus.rf_we), 32'd1);
        chk("add_wb_pc_we", 32'(bus.pc_we), 32'd1);
        chk("add_wb_sel", 32'(bus.wb_sel), 32'd0);
        tick();
        chk("add_back_fetch", 32'(bus.state), 32'd1);
        chk("add_instret", bus.instret, 32'd1);

        // LW: 1,2,3,4,5
        bus.opcode = 7'b0000011;
        tick(); chk("lw_decode", 32'(bus.state), 32'd2);
        tick(); chk("lw_exec_alu_b", 32'(bus.alu_b_sel), 32'd1);
        tick(); show("lw_mem");
        chk("lw_mem_state", 32'(bus.state), 32'd4);
        chk("lw_mem_dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("lw_mem_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("lw_mem_pc_we", 32'(bus.pc_we), 32'd0);
        tick(); show("lw_wb");
        chk("lw_wb_state", 32'(bus.state), 32'd5);
        chk("lw_wb_sel", 32'(bus.wb_sel), 32'd1);
        tick(); chk("lw_back_fetch", 32'(bus.state), 32'd1);

        // SW: 1,2,3,4,1
        bus.opcode = 7'b0100011;
        tick(); tick();
        chk("sw_exec_rf_we", 32'(bus.rf_we), 32'd0);
        tick(); show("sw_mem");
        chk("sw_mem_state", 32'(bus.state), 32'd4);
        chk("sw_mem_dmem_we", 32'(bus.dmem_we), 32'd1);
        chk("sw_mem_pc_we", 32'(bus.pc_we), 32'd1);
        chk("sw_mem_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("sw_mem_rf_we", 32'(bus.rf_we), 32'd0);
        tick();
        chk("sw_back_fetch", 32'(bus.state), 32'd1);
        chk("sw_instret", bus.instret, 32'd3);

        // BEQ taken then not taken
        bus.opcode = 7'b1100011;
        bus.branch_taken = 1'b1;
        tick(); tick(); show("beq_t_exec");
        chk("beq_t_pc_we", 32'(bus.pc_we), 32'd1);
        chk("beq_t_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("beq_t_rf_we", 32'(bus.rf_we), 32'd0);
        chk("beq_t_alu_b", 32'(bus.alu_b_sel), 32'd0);
        tick(); chk("beq_t_fetch", 32'(bus.state), 32'd1);
        bus.branch_taken = 1'b0;
        tick(); tick(); show("beq_nt_exec");
        chk("beq_nt_pc_we", 32'(bus.pc_we), 32'd1);
        chk("beq_nt_pc_sel", 32'(bus.pc_sel), 32'd0);
        tick();
        chk("beq_nt_fetch", 32'(bus.state), 32'd1);
        chk("beq_instret", bus.instret, 32'd5);

        // JAL, AUIPC, LUI
        bus.opcode = 7'b1101111;
        tick(); tick(); tick(); show("jal_wb");
        chk("jal_wb_sel", 32'(bus.wb_sel), 32'd2);
        chk("jal_pc_sel", 32'(bus.pc_sel), 32'd1);
        tick();
        bus.opcode = 7'b0010111;
        tick(); tick();
        chk("auipc_alu_a", 32'(bus.alu_a_sel), 32'd1);
        chk("auipc_alu_b", 32'(bus.alu_b_sel), 32'd1);
        tick(); chk("auipc_wb_sel", 32'(bus.wb_sel), 32'd0);
        chk("auipc_pc_sel", 32'(bus.pc_sel), 32'd0);
        tick();
        bus.opcode = 7'b0110111;
        tick(); tick();
        chk("lui_alu_a", 32'(bus.alu_a_sel), 32'd0);
        tick(); chk("lui_wb_sel", 32'(bus.wb_sel), 32'd3);
        tick();
        chk("lui_instret", bus.instret, 32'd8);

        // Fetch stall: ready arrives on the 15th waiting cycle, no trap
        bus.opcode = 7'b0110011;
        bus.imem_ready = 1'b0;
        #1;
        chk("stall_ir_we", 32'(bus.ir_we), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        chk("stall_c15_state", 32'(bus.state), 32'd1);
        bus.imem_ready = 1'b1;
        #1;
        chk("stall_c15_ir_we", 32'(bus.ir_we), 32'd1);
        tick(); show("stall_recover");
        chk("stall_decode", 32'(bus.state), 32'd2);
        tick(); tick(); tick();
        chk("stall_instret", bus.instret, 32'd9);

        // Fetch timeout: 15 waiting cycles -> TRAP cause 2
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("ito_c15_state", 32'(bus.state), 32'd1);
        tick(); show("imem_timeout");
        chk("ito_state", 32'(bus.state), 32'd7);
        chk("ito_cause", 32'(bus.trap_cause), 32'd2);
        chk("ito_imem_req", 32'(bus.imem_req), 32'd0);
        bus.imem_ready = 1'b1;
        tick();
        chk("ito_absorb", 32'(bus.state), 32'd7);
        chk("ito_pc_we", 32'(bus.pc_we), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("ito_rst_state", 32'(bus.state), 32'd0);
        chk("ito_rst_instret", bus.instret, 32'd0);
        chk("ito_rst_cause", 32'(bus.trap_cause), 32'd0);

        // Illegal opcode (AMO) -> TRAP cause 1
        bus.opcode = 7'b0101111;
        bus.run = 1'b1;
        tick(); tick(); tick(); show("illegal");
        chk("ill_state", 32'(bus.state), 32'd7);
        chk("ill_cause", 32'(bus.trap_cause), 32'd1);
        chk("ill_pc_we", 32'(bus.pc_we), 32'd0);
        chk("ill_instret", bus.instret, 32'd0);
        rst = 1'b1; tick(); rst = 1'b0; bus.run = 1'b0; #1;
        chk("ill_rst_state", 32'(bus.state), 32'd0);

        // SYSTEM -> HALT
        bus.opcode = 7'b1110011;
        bus.run = 1'b1;
        tick(); bus.run = 1'b0;
        tick(); tick(); show("halt");
        chk("halt_state", 32'(bus.state), 32'd6);
        chk("halt_cause", 32'(bus.trap_cause), 32'd0);
        chk("halt_rf_we", 32'(bus.rf_we), 32'd0);
        chk("halt_imem_req", 32'(bus.imem_req), 32'd0);
        bus.run = 1'b1;
        tick();
        chk("halt_absorb", 32'(bus.state), 32'd6);
        chk("halt_instret", bus.instret, 32'd0);
        rst = 1'b1; tick(); rst = 1'b0; bus.run = 1'b0; #1;
        chk("halt_rst_state", 32'(bus.state), 32'd0);

        // Data timeout in MEM -> TRAP cause 3
        bus.opcode = 7'b0000011;
        bus.run = 1'b1;
        tick(); bus.run = 1'b0;
        tick(); tick(); tick();
        bus.dmem_ready = 1'b0;
        #1;
        chk("dto_mem_state", 32'(bus.state), 32'd4);
        for (int i = 0; i < 14; i++) tick();
        chk("dto_c15_state", 32'(bus.state), 32'd4);
        tick(); show("dmem_timeout");
        chk("dto_state", 32'(bus.state), 32'd7);
        chk("dto_cause", 32'(bus.trap_cause), 32'd3);
        bus.dmem_ready = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("dto_rst_state", 32'(bus.state), 32'd0);

        // Reset in MEM with dmem_ready in the same cycle
        bus.run = 1'b1;
        tick(); bus.run = 1'b0;
        tick(); tick(); tick();
        chk("rmem_state", 32'(bus.state), 32'd4);
        rst = 1'b1;
        tick(); rst = 1'b0; #1; show("rst_in_mem");
        chk("rmem_idle", 32'(bus.state), 32'd0);
        chk("rmem_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rmem_pc_we", 32'(bus.pc_we), 32'd0);
        chk("rmem_instret", bus.instret, 32'd0);
        chk("rmem_dmem_req", 32'(bus.dmem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles a memory request may wait for ready before timeout trap.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port run  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port opcode  input  7  opcode field from the instruction decoder, sampled in DECODE.
REQ-006 SHALL have port branch_taken  input  1  branch comparator result, valid in EXEC.
REQ-007 SHALL have port imem_ready  input  1  instruction memory accept/return strobe.
REQ-008 SHALL have port dmem_ready  input  1  data memory accept/return strobe.
REQ-009 SHALL have port imem_req  output  1  instruction fetch request.
REQ-010 SHALL have port ir_we  output  1  instruction register write strobe.
REQ-011 SHALL have port dmem_req / dmem_we  output  1 each  data access request / store qualifier.
REQ-012 SHALL have port rf_we  output  1  register file write strobe.
REQ-013 SHALL have port pc_we  output  1  PC write strobe; pc_sel  output  1  0=PC+4, 1=computed target.
REQ-014 SHALL have port alu_a_sel / alu_b_sel  output  1 each  0=rs1/rs2, 1=PC/imm.
REQ-015 SHALL have port wb_sel  output  2  0=ALU, 1=load data, 2=PC+4, 3=imm.
REQ-016 SHALL have port state  output  3  current state encoding (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7).
REQ-017 SHALL have port trap_cause  output  2  0=none, 1=illegal opcode, 2=imem timeout, 3=dmem timeout; and instret  output  32  retired-instruction count.

Function
REQ-018 SHALL be a Moore FSM; all control outputs SHALL decode from the state register and the latched opcode (op_q), with imem_req, dmem_req and timeout checks additionally qualified by the ready inputs as stated below.
REQ-019 IDLE: all strobes 0; go to FETCH on run=1.
REQ-020 FETCH: imem_req=1; on imem_ready=1, ir_we=1 in that cycle and next state DECODE; otherwise remain in FETCH.
REQ-021 DECODE: latch op_q<=opcode; go to EXEC for 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0010111, 0110111; go to HALT for 1110011; any other value (including 0101111) go to TRAP with trap_cause=1.
REQ-022 EXEC: alu_a_sel=1 only for 0010111; alu_b_sel=1 for every op_q except 0110011 and 1100011.
REQ-023 EXEC next state: loads/stores go to MEM; branches go to FETCH with pc_we=1, pc_sel=branch_taken; all others go to WB.
REQ-024 MEM: dmem_req=1, dmem_we=1 only for stores; on dmem_ready=1 loads go to WB and stores go to FETCH with pc_we=1, pc_sel=0.
REQ-025 WB: rf_we=1 and pc_we=1 for one cycle, then FETCH; wb_sel=1 load, 2 JAL/JALR, 3 LUI, else 0; pc_sel=1 for JAL/JALR, else 0.
REQ-026 Each executed instruction SHALL assert pc_we exactly once; HALT/TRAP instructions never assert pc_we or rf_we.
REQ-027 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle ready is low; when it reaches WAIT_MAX with ready still low, next state TRAP with cause 2 (FETCH) or 3 (MEM); ready high in that same cycle wins over timeout.
REQ-028 instret SHALL increment by 1 on the cycle pc_we=1; it wraps from 0xFFFFFFFF to 0.
REQ-029 HALT and TRAP SHALL be absorbing: all strobes 0, trap_cause held, exit only via rst.
REQ-030 run is examined only in IDLE; deasserting it mid-instruction SHALL have no effect.

Reset
REQ-031 With rst=1 at a rising edge, next state SHALL be IDLE, op_q=0, wait counter=0, trap_cause=0, instret=0, and all strobes 0 from the following cycle, regardless of state or pending memory request.
REQ-032 Reset SHALL take priority over every transition, including ready arriving in the same cycle.

Verification
REQ-033 ADD (0110011), imem/dmem ready immediate -> states 1,2,3,5,1; rf_we and pc_we high in WB only, wb_sel=0; instret 0->1.
REQ-034 LW then SW -> LW: 1,2,3,4,5 with wb_sel=1; SW: 1,2,3,4,1 with dmem_we=1 in MEM, rf_we never high; instret=2.
REQ-035 BEQ with branch_taken=1, then with 0 -> pc_we in EXEC, pc_sel 1 then 0; back to FETCH; rf_we never high.
REQ-036 imem_ready held low in FETCH, WAIT_MAX=15 -> state=7, trap_cause=2 after 15 waiting cycles; ready on cycle 15 -> DECODE, no trap.
REQ-037 opcode 0101111 -> TRAP, trap_cause=1; opcode 1110011 -> HALT, no strobes; in each, rst=1 for one edge -> IDLE, instret=0.
REQ-038 rst asserted in MEM with dmem_ready=1 same cycle -> IDLE next cycle, no rf_we, pc_we or instret change.
